// File: rtl/bubble_position_tracker.sv
// Bubble-memory field rotation tracker: synchronizes host strobes, counts rotation steps
// around the loop and raises page requests on replicate strobes. Optional OVERRUN_FLAG_EN adds a sticky overrun flag.
module bubble_position_tracker #(
  parameter int CYCLE_LEN = 480,
  parameter int POSITIONS = 2053
) (
  input  logic        master_clock,
  input  logic        reset,
  input  logic        bubble_shift_enable,
  input  logic        replicator_enable,
  input  logic        bootloop_enable,
  input  logic        page_ack,
  output logic        shifting,
  output logic        step_tick,
  output logic [11:0] position,
  output logic        page_req,
  output logic [11:0] page_addr,
  output logic        boot_req,
  output logic        overrun
);

  localparam int                CNT_W    = (CYCLE_LEN > 1) ? $clog2(CYCLE_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLE_LEN - 1);
  localparam logic [11:0]      POS_LAST = 12'(POSITIONS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_REQ
  } state_e;

  // Synchronizer stages; replicator carries a third stage to see its falling edge.
  logic [1:0]       shift_sync_q;
  logic [2:0]       rep_sync_q;
  logic [1:0]       boot_sync_q;

  logic             shifting_q;
  logic             shifting_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [11:0]      position_q;
  logic [11:0]      position_d;
  logic             boot_req_q;
  logic             boot_req_d;
  state_e           state_q;
  logic             page_req_q;
  logic [11:0]      page_addr_q;

  logic             shift_rise;
  logic             tick;
  logic             rep_event;
  logic             boot_phase;

  // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge master_clock) begin
    if (reset) begin
      shift_sync_q <= '1;
      rep_sync_q   <= '1;
      boot_sync_q  <= '1;
    end else begin
      shift_sync_q <= {shift_sync_q[0], bubble_shift_enable};
      rep_sync_q   <= {rep_sync_q[1:0], replicator_enable};
      boot_sync_q  <= {boot_sync_q[0], bootloop_enable};
    end
  end

  assign boot_phase = ~boot_sync_q[1];
  assign shifting_d = ~shift_sync_q[1];
  assign shift_rise = shifting_d & ~shifting_q;
  assign tick       = shifting_q & (cnt_q == CNT_LAST);
  assign rep_event  = shifting_q & boot_sync_q[1] & rep_sync_q[2] & ~rep_sync_q[1];
  assign boot_req_d = shift_rise & boot_phase;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cnt_d      = '0;
    position_d = position_q;
    if (shifting_q && !tick) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (tick) begin
      position_d = (position_q == POS_LAST) ? 12'd0 : position_q + 12'd1;
    end else if (boot_req_d) begin
      position_d = 12'd0;
    end
  end

  always_ff @(posedge master_clock) begin
    if (reset) begin
      shifting_q <= 1'b0;
      cnt_q      <= '0;
      position_q <= 12'd0;
      boot_req_q <= 1'b0;
    end else begin
      shifting_q <= shifting_d;
      cnt_q      <= cnt_d;
      position_q <= position_d;
      boot_req_q <= boot_req_d;
    end
  end

  // The request address is the position seen before any increment on the same edge.
  always_ff @(posedge master_clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      page_req_q  <= 1'b0;
      page_addr_q <= 12'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (shifting_d) state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (rep_event) begin
            state_q     <= ST_REQ;
            page_req_q  <= 1'b1;
            page_addr_q <= position_q;
          end else if (!shifting_d) begin
            state_q <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (page_ack) begin
            state_q    <= shifting_d ? ST_SHIFT : ST_IDLE;
            page_req_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          page_req_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef OVERRUN_FLAG_EN
  logic overrun_q;

  always_ff @(posedge master_clock) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else if (state_q == ST_REQ && rep_event) begin
      overrun_q <= 1'b1;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

  assign shifting  = shifting_q;
  assign step_tick = tick;
  assign position  = position_q;
  assign page_req  = page_req_q;
  assign page_addr = page_addr_q;
  assign boot_req  = boot_req_q;

endmodule

// File: tb/tb_bubble_position_tracker.sv
// Self-checking bench for bubble_position_tracker: directed scenarios plus randomized
// stimulus compared every cycle against a behavioural model of the tracker.
module tb_bubble_position_tracker;

  localparam int CYC = 4;
  localparam int POS = 8;

  logic        master_clock = 1'b0;
  logic        reset;
  logic        bubble_shift_enable;
  logic        replicator_enable;
  logic        bootloop_enable;
  logic        page_ack;
  logic        shifting;
  logic        step_tick;
  logic [11:0] position;
  logic        page_req;
  logic [11:0] page_addr;
  logic        boot_req;
  logic        overrun;

  bubble_position_tracker #(
    .CYCLE_LEN(CYC),
    .POSITIONS(POS)
  ) dut (
    .master_clock       (master_clock),
    .reset              (reset),
    .bubble_shift_enable(bubble_shift_enable),
    .replicator_enable  (replicator_enable),
    .bootloop_enable    (bootloop_enable),
    .page_ack           (page_ack),
    .shifting           (shifting),
    .step_tick          (step_tick),
    .position           (position),
    .page_req           (page_req),
    .page_addr          (page_addr),
    .boot_req           (boot_req),
    .overrun            (overrun)
  );

  always #5 master_clock = ~master_clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: input delay lines plus integer loop arithmetic.
  bit m_shifting, m_req, m_ov, m_boot;
  int m_cnt, m_pos, m_addr;
  bit sh_dl[3];
  bit rep_dl[3];
  bit bt_dl[3];

  task automatic model_edge();
    bit new_sh, tick, ev, rise;
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        sh_dl[i] = 1'b1; rep_dl[i] = 1'b1; bt_dl[i] = 1'b1;
      end
      m_shifting = 0; m_req = 0; m_ov = 0; m_boot = 0;
      m_cnt = 0; m_pos = 0; m_addr = 0;
      return;
    end
    new_sh = !sh_dl[1];
    tick   = m_shifting && (m_cnt == CYC - 1);
    ev     = m_shifting && bt_dl[1] && rep_dl[2] && !rep_dl[1];
    rise   = new_sh && !m_shifting;
    if (m_req) begin
      if (ev) m_ov = 1;
      if (page_ack) m_req = 0;
    end else if (ev) begin
      m_req  = 1;
      m_addr = m_pos;
    end
    m_boot = rise && !bt_dl[1];
    if (tick) m_pos = (m_pos + 1) % POS;
    else if (m_boot) m_pos = 0;
    m_cnt      = m_shifting ? (m_cnt + 1) % CYC : 0;
    m_shifting = new_sh;
    for (int i = 2; i > 0; i--) begin
      sh_dl[i] = sh_dl[i-1]; rep_dl[i] = rep_dl[i-1]; bt_dl[i] = bt_dl[i-1];
    end
    sh_dl[0]  = bubble_shift_enable;
    rep_dl[0] = replicator_enable;
    bt_dl[0]  = bootloop_enable;
  endtask

  task automatic step();
    bit exp_ov;
    @(posedge master_clock);
    model_edge();
    #1;
`ifdef OVERRUN_FLAG_EN
    exp_ov = m_ov;
`else
    exp_ov = 1'b0;
`endif
    check("shifting",  32'(shifting),  32'(m_shifting));
    check("step_tick", 32'(step_tick), 32'(m_shifting && (m_cnt == CYC - 1)));
    check("position",  32'(position),  32'(m_pos));
    check("page_req",  32'(page_req),  32'(m_req));
    check("page_addr", 32'(page_addr), 32'(m_addr));
    check("boot_req",  32'(boot_req),  32'(m_boot));
    check("overrun",   32'(overrun),   32'(exp_ov));
  endtask

  // Replicator low for one clock; the synchronized falling edge is acted on at the third edge.
  task automatic rep_pulse();
    replicator_enable = 1'b0;
    step();
    replicator_enable = 1'b1;
    step();
    step();
  endtask

  int  ticks;
  int  boots;
  bit  found;

  initial begin
    reset               = 1'b1;
    bubble_shift_enable = 1'b1;
    replicator_enable   = 1'b1;
    bootloop_enable     = 1'b1;
    page_ack            = 1'b0;
    repeat (3) step();
    check("rst_position", 32'(position), 32'd0);
    check("rst_page_req", 32'(page_req), 32'd0);
    reset = 1'b0;

    // 40 clocks of shifting with a 4-clock step and an 8-position loop.
    bubble_shift_enable = 1'b0;
    ticks = 0;
    repeat (40) begin step(); ticks += 32'(step_tick); end
    bubble_shift_enable = 1'b1;
    repeat (10) begin step(); ticks += 32'(step_tick); end
    check("wrap_ticks", 32'(ticks), 32'd10);
    check("wrap_pos", 32'(position), 32'd2);
    ticks = 0;
    repeat (8) begin step(); ticks += 32'(step_tick); end
    check("frozen_ticks", 32'(ticks), 32'd0);
    check("frozen_pos", 32'(position), 32'd2);

    // Replicate at position 3 on the same edge as a step.
    bubble_shift_enable = 1'b0;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      found = m_shifting && (m_pos == 3) && (m_cnt == 1);
    end
    check("align3_found", 32'(found), 32'd1);
    rep_pulse();
    check("req_addr", 32'(page_addr), 32'd3);
    check("req_pos", 32'(position), 32'd4);
    check("req_high", 32'(page_req), 32'd1);

    // Second replicate while the request is outstanding.
    rep_pulse();
    step();
    check("second_addr", 32'(page_addr), 32'd3);
    check("second_req", 32'(page_req), 32'd1);
`ifdef OVERRUN_FLAG_EN
    check("second_overrun", 32'(overrun), 32'd1);
`else
    check("second_overrun", 32'(overrun), 32'd0);
`endif
    page_ack = 1'b1;
    step();
    page_ack = 1'b0;
    check("ack_drop", 32'(page_req), 32'd0);
    step();
    check("ack_stay", 32'(page_req), 32'd0);

    // Shift released during a request, acked 10 clocks later.
    rep_pulse();
    check("req2_high", 32'(page_req), 32'd1);
    bubble_shift_enable = 1'b1;
    repeat (10) step();
    check("req2_held", 32'(page_req), 32'd1);
    check("req2_stopped", 32'(shifting), 32'd0);
    page_ack = 1'b1;
    step();
    page_ack = 1'b0;
    check("req2_ack", 32'(page_req), 32'd0);

    // Reset in the middle of a request.
    bubble_shift_enable = 1'b0;
    repeat (5) step();
    rep_pulse();
    check("req3_high", 32'(page_req), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_req", 32'(page_req), 32'd0);
    check("rst_mid_pos", 32'(position), 32'd0);

    // Bootloader phase: shift start from position 5 reloads position 0.
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      found = (m_pos == 5);
    end
    check("align5_found", 32'(found), 32'd1);
    bubble_shift_enable = 1'b1;
    repeat (6) step();
    check("pos5_held", 32'(position), 32'd5);
    bootloop_enable = 1'b0;
    repeat (4) step();
    bubble_shift_enable = 1'b0;
    boots = 0;
    repeat (12) begin
      step();
      if (boot_req) begin
        boots++;
        check("boot_pos", 32'(position), 32'd0);
      end
    end
    check("boot_pulses", 32'(boots), 32'd1);
    rep_pulse();
    step();
    check("boot_no_req", 32'(page_req), 32'd0);

    // Replicate pulse while not shifting.
    bubble_shift_enable = 1'b1;
    bootloop_enable     = 1'b1;
    repeat (6) step();
    rep_pulse();
    repeat (3) step();
    check("idle_no_req", 32'(page_req), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) bubble_shift_enable = ~bubble_shift_enable;
      replicator_enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 199) == 0) bootloop_enable = ~bootloop_enable;
      page_ack = ($urandom_range(0, 5) == 0);
      reset    = ($urandom_range(0, 499) == 0);
      step();
    end
    reset    = 1'b0;
    page_ack = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
